// File: rtl/mmu_mbc_dma.sv
// MBC1 bank mapper, sticky BIOS-unmap latch and OAM DMA engine sitting between the CPU bus and storage.
// Mapping is combinational; DMA issues one read per cycle and writes OAM DMA_READ_LATENCY cycles later while blocking non-FFxx CPU accesses.
module mmu_mbc_dma #(
    parameter int ROM_BANK_BITS    = 7,
    parameter int RAM_BANK_BITS    = 2,
    parameter int MBC_ENABLE       = 1,
    parameter int DMA_LEN          = 160,
    parameter int DMA_READ_LATENCY = 1
) (
    input  logic                       iClock,
    input  logic                       iReset,
    input  logic [15:0]                iCpuAddr,
    input  logic                       iCpuWe,
    input  logic [7:0]                 iCpuData,
    output logic [7:0]                 oCtrlReadData,
    output logic                       oCtrlReadHit,
    output logic                       oCpuBlocked,
    output logic                       oBiosEnable,
    output logic [14+ROM_BANK_BITS-1:0] oRomAddr,
    output logic [13+RAM_BANK_BITS-1:0] oExtRamAddr,
    output logic                       oExtRamEnable,
    output logic                       oDmaReadReq,
    output logic [15:0]                oDmaReadAddr,
    input  logic [7:0]                 iDmaReadData,
    output logic                       oOamWe,
    output logic [7:0]                 oOamAddr,
    output logic [7:0]                 oOamData,
    output logic                       oDmaActive
);
    localparam int L  = DMA_READ_LATENCY;
    localparam int IW = $clog2(DMA_LEN + 1);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} dma_state_t;

    dma_state_t                 r_state, w_state_nxt;
    logic [4:0]                 r_rom_lo;
    logic [1:0]                 r_upper;
    logic                       r_mode, r_ram_en, r_bios;
    logic [7:0]                 r_dma_src;
    logic [IW-1:0]              r_idx;
    logic [L-1:0]               r_pv;
    logic [IW-1:0]              r_pi [L];

    logic                       w_wr, w_dma_start, w_issue, w_last_wr;
    logic [7:0]                 w_src_hi;
    logic [ROM_BANK_BITS-1:0]   w_bank;

    assign oDmaActive  = (r_state == S_RUN);
    assign oCpuBlocked = oDmaActive && (iCpuAddr < 16'hFF00);
    assign w_wr        = iCpuWe && !oCpuBlocked;
    assign w_dma_start = iCpuWe && (iCpuAddr == 16'hFF46);
    assign oBiosEnable = r_bios;

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            r_rom_lo  <= 5'd1;
            r_upper   <= 2'd0;
            r_mode    <= 1'b0;
            r_ram_en  <= 1'b0;
            r_bios    <= 1'b1;
            r_dma_src <= 8'h00;
        end else begin
            if (w_wr && (MBC_ENABLE != 0)) begin
                case (iCpuAddr[15:13])
                    3'b000:  r_ram_en <= (iCpuData[3:0] == 4'hA);
                    3'b001:  r_rom_lo <= (iCpuData[4:0] == 5'd0) ? 5'd1 : iCpuData[4:0];
                    3'b010:  r_upper  <= iCpuData[1:0];
                    3'b011:  r_mode   <= iCpuData[0];
                    default: ;
                endcase
            end
            // Sticky: once the BIOS is unmapped only reset brings it back.
            if (w_wr && (iCpuAddr == 16'hFF50) && (iCpuData != 8'h00))
                r_bios <= 1'b0;
            if (w_dma_start)
                r_dma_src <= iCpuData;
        end
    end

    always_comb begin
        w_bank = ROM_BANK_BITS'(0);
        if (MBC_ENABLE == 0)
            w_bank = iCpuAddr[14] ? ROM_BANK_BITS'(1) : ROM_BANK_BITS'(0);
        else if (iCpuAddr[14])
            w_bank = ROM_BANK_BITS'({r_upper, r_rom_lo});
        else if (r_mode)
            w_bank = ROM_BANK_BITS'({r_upper, 5'b0});
    end
    assign oRomAddr = {w_bank, iCpuAddr[13:0]};

    assign oExtRamEnable = (MBC_ENABLE != 0) && r_ram_en && (iCpuAddr[15:13] == 3'b101);

    generate
        if (RAM_BANK_BITS == 0) begin : g_ram_single
            assign oExtRamAddr = iCpuAddr[12:0];
        end else begin : g_ram_banked
            logic [RAM_BANK_BITS-1:0] w_ram_bank;
            assign w_ram_bank  = r_mode ? RAM_BANK_BITS'(r_upper) : '0;
            assign oExtRamAddr = {w_ram_bank, iCpuAddr[12:0]};
        end
    endgenerate

    always_comb begin
        oCtrlReadHit  = 1'b0;
        oCtrlReadData = 8'h00;
        if (iCpuAddr == 16'hFF46) begin
            oCtrlReadHit  = 1'b1;
            oCtrlReadData = r_dma_src;
        end else if (iCpuAddr == 16'hFF50) begin
            oCtrlReadHit  = 1'b1;
            oCtrlReadData = {7'h7F, r_bios};
        end
    end

    // Sources at E0xx and above fold back onto WRAM (echo region).
    assign w_src_hi     = (r_dma_src >= 8'hE0) ? (r_dma_src - 8'h20) : r_dma_src;
    assign w_issue      = (r_state == S_RUN) && (r_idx < IW'(DMA_LEN));
    assign oDmaReadReq  = w_issue;
    assign oDmaReadAddr = w_issue ? ({w_src_hi, 8'h00} + 16'(r_idx)) : 16'h0000;
    assign w_last_wr    = r_pv[L-1] && (r_pi[L-1] == IW'(DMA_LEN - 1));
    assign oOamWe       = (r_state == S_RUN) && r_pv[L-1];
    assign oOamAddr     = oOamWe ? 8'(r_pi[L-1]) : 8'h00;
    assign oOamData     = oOamWe ? iDmaReadData : 8'h00;

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_dma_start) w_state_nxt = S_RUN;
            S_RUN:  if (w_dma_start) w_state_nxt = S_RUN;
                    else if (w_last_wr) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A restart flushes the capture pipeline so stale reads never reach OAM.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            r_idx <= '0;
            r_pv  <= '0;
            for (int k = 0; k < L; k++) r_pi[k] <= '0;
        end else if (w_dma_start) begin
            r_idx <= '0;
            r_pv  <= '0;
        end else begin
            if (w_issue) r_idx <= r_idx + 1'b1;
            r_pv[0] <= w_issue;
            r_pi[0] <= r_idx;
            for (int k = 1; k < L; k++) begin
                r_pv[k] <= r_pv[k-1];
                r_pi[k] <= r_pi[k-1];
            end
        end
    end
endmodule

// File: doc/mmu_mbc_dma.md
Name: mmu_mbc_dma

Overview:
- Parametrised successor to the flat MMU decode.
- Adds three things:
  - MBC1-style ROM/RAM bank mapping with physical address generation.
  - A sticky BIOS-unmap latch at FF50.
  - A cycle-accurate OAM DMA engine at FF46 that copies 160 bytes into sprite OAM and blocks the CPU bus while it runs.
- Sits between the CPU bus and the cartridge/VRAM/WRAM/OAM storage. Read data muxing of the storage arrays stays in the top MMU.

Parameters:
- ROM_BANK_BITS, 7, number of ROM bank bits implemented (2..7); bank numbers are masked to this width.
- RAM_BANK_BITS, 2, number of external RAM bank bits (0..2); 0 means a single 8 KB bank.
- MBC_ENABLE, 1, 0 = ROM-only cartridge: bank registers are ignored and ROM bank is fixed at 1.
- DMA_LEN, 160, number of bytes per OAM DMA transfer.
- DMA_READ_LATENCY, 1, cycles from oDmaReadAddr valid to iDmaReadData valid (1..3).

Ports:
- iClock  in  1  system clock; all state updates on the rising edge.
- iReset  in  1  asynchronous, active-high reset.
- iCpuAddr  in  16  CPU address.
- iCpuWe  in  1  CPU write strobe, one cycle per write.
- iCpuData  in  8  CPU write data.
- oCtrlReadData  out  8  read-back data for FF46/FF50.
- oCtrlReadHit  out  1  high when iCpuAddr is FF46 or FF50.
- oCpuBlocked  out  1  the CPU access is void; the top MMU returns 8'hFF and suppresses the write.
- oBiosEnable  out  1  BIOS overlay active for 0000-00FF.
- oRomAddr  out  14+ROM_BANK_BITS  physical ROM address.
- oExtRamAddr  out  13+RAM_BANK_BITS  physical external RAM address.
- oExtRamEnable  out  1  external RAM access enabled.
- oDmaReadReq  out  1  DMA source read strobe.
- oDmaReadAddr  out  16  DMA source address.
- iDmaReadData  in  8  DMA source data.
- oOamWe  out  1  OAM write strobe.
- oOamAddr  out  8  OAM write address (0..DMA_LEN-1).
- oOamData  out  8  OAM write data.
- oDmaActive  out  1  DMA in progress.

Behaviour:
- Reset values:
  - Registers: rRomLo=1, rUpper=0, rMode=0, rRamEn=0, rDmaSrc=0, rBios=1, DMA state IDLE.
  - Outputs: all outputs 0 except oBiosEnable=1 and oCtrlReadData=0.
- Reset asserted mid-DMA aborts the transfer immediately; no further OAM writes occur.
- MBC registers (MBC_ENABLE=1). All are updated on a CPU write edge only when oCpuBlocked=0.
  - 0000-1FFF: rRamEn = (iCpuData[3:0]==4'hA).
  - 2000-3FFF: rRomLo = iCpuData[4:0]; a written value of 0 stores 1.
  - 4000-5FFF: rUpper = iCpuData[1:0].
  - 6000-7FFF: rMode = iCpuData[0].
- Bank mapping:
  - ROM bank for 4000-7FFF = {rUpper,rRomLo} masked to ROM_BANK_BITS.
  - ROM bank for 0000-3FFF = rMode ? {rUpper,5'b0} masked : 0.
  - oRomAddr = {bank, iCpuAddr[13:0]}, combinational.
  - RAM bank = rMode ? rUpper masked to RAM_BANK_BITS : 0.
  - oExtRamAddr = {ramBank, iCpuAddr[12:0]}.
  - oExtRamEnable = rRamEn & (iCpuAddr[15:13]==3'b101).
  - With MBC_ENABLE=0, bank is 0 for 0000-3FFF and 1 for 4000-7FFF, and oExtRamEnable=0.
- BIOS latch:
  - A CPU write of a nonzero value to FF50 clears rBios.
  - rBios is sticky; writing 0 never sets it again; only reset restores it.
  - oBiosEnable = rBios.
  - FF50 read-back = {7'h7F, rBios}.
- DMA engine:
  - States: IDLE and RUN. A per-byte issue index i counts 0..DMA_LEN-1.
  - A write to FF46 stores rDmaSrc = iCpuData and enters RUN with i=0 on the next edge.
  - A write to FF46 while in RUN restarts the transfer: new source, i=0; in-flight reads from the old source are discarded.
  - Source base = {rDmaSrc,8'h00}; if rDmaSrc >= 8'hE0 the high byte used is rDmaSrc-8'h20 (echo of WRAM).
  - Issue: in RUN, each cycle asserts oDmaReadReq with oDmaReadAddr = base+i, then i increments.
  - Capture: a DMA_READ_LATENCY-deep valid/index pipeline aligns returned data; exactly DMA_READ_LATENCY cycles after issue of index i, oOamWe=1, oOamAddr=i, oOamData=iDmaReadData.
  - Completion: after issuing i=DMA_LEN-1, issuing stops; oDmaActive stays high until the last OAM write cycle, then the engine returns to IDLE.
  - Total oDmaActive time = DMA_LEN+DMA_READ_LATENCY cycles.
  - FF46 read-back = rDmaSrc.
- CPU blocking:
  - oCpuBlocked = oDmaActive & (iCpuAddr < 16'hFF00).
  - FF00-FFFF, which covers IO, FF46 and HRAM, remains accessible during DMA.
- oCtrlReadHit and oCtrlReadData are combinational from iCpuAddr and register state.

Test Plan:
1. Reset -> oBiosEnable=1, bank 1 at 4000, and a read at addr 4123 gives oRomAddr=0x4123. Write 0x01 to FF50 -> oBiosEnable=0; then write 0x00 to FF50 -> it stays 0, and FF50 reads back 0xFE.
2. Write 0x00 to 2000 -> bank 1 (oRomAddr for 4000 = 0x4000). Write 0x1F to 2000 and 0x03 to 4000 -> bank 0x7F, so addr 7FFF gives 0x1FFFFF. Then write 1 to 6000 -> addr 0000 maps to 0x180000, RAM bank 3, and A000 gives oExtRamAddr=0x6000.
3. Write 0x0A to 0000 -> oExtRamEnable=1 at B000. Write 0x0B to 0000 -> oExtRamEnable=0.
4. Write 0xC1 to FF46 with a memory model of latency 1 -> oOamWe pulses 160 consecutive cycles with addresses 0..159 and data from C100..C19F, and oDmaActive is high for exactly 161 cycles. During the transfer, CPU reads of C000 give oCpuBlocked=1 and reads of FF80 give 0.
5. Write 0xE2 to FF46 -> oDmaReadAddr starts at C200.
6. Restart at byte 50 with 0xD0 to FF46 -> the next OAM write after the latency is to addr 0 with data from D000. Assert iReset at byte 80 -> oOamWe and oDmaActive drop immediately and all registers return to reset values.
